// File: rtl/i2c_axis_target.sv
// I2C target on one fixed 7-bit address. Written bytes leave on an AXI-Stream master port
// and read bytes come from an AXI-Stream slave port. SCL and SDA are oversampled on clk_i.
module i2c_axis_target #(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tuser,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       busy_o
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_WR_DATA  = 3'd3;
    localparam logic [2:0] S_WR_ACK   = 3'd4;
    localparam logic [2:0] S_RD_DATA  = 3'd5;
    localparam logic [2:0] S_RD_ACK   = 3'd6;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;
    logic [2:0]             r_state;
    logic [3:0]             r_cnt;
    logic [7:0]             r_shift;
    logic                   r_rw, r_phase, r_ack, r_first;
    logic                   r_oe, r_tvalid, r_tuser, r_s_tready, r_busy;
    logic [7:0]             r_tdata;

    logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop, w_free;
    logic [7:0] w_shift, w_rd_byte;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_sda_rise = w_sda & ~r_sda_d;
    assign w_sda_fall = ~w_sda & r_sda_d;
    // SCL must be high on both the current and previous sample to call a bus condition
    assign w_start    = w_sda_fall & w_scl & r_scl_d;
    assign w_stop     = w_sda_rise & w_scl & r_scl_d;
    assign w_shift    = {r_shift[6:0], w_sda};
    assign w_free     = ~r_tvalid | m_axis_tready;
    assign w_rd_byte  = s_axis_tvalid ? s_axis_tdata : 8'hFF;

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_shift    <= 8'd0;
            r_rw       <= 1'b0;
            r_phase    <= 1'b0;
            r_ack      <= 1'b0;
            r_first    <= 1'b0;
            r_oe       <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tuser    <= 1'b0;
            r_tdata    <= 8'd0;
            r_s_tready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_s_tready <= 1'b0;
            // The output handshake completes regardless of bus conditions; a push below overrides it
            if (r_tvalid && m_axis_tready) r_tvalid <= 1'b0;
            if (w_stop) begin
                r_state <= S_IDLE;
                r_oe    <= 1'b0;
                r_busy  <= 1'b0;
            end else if (w_start) begin
                r_state <= S_ADDR;
                r_cnt   <= 4'd0;
                r_oe    <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: if (w_scl_rise) begin
                        r_shift <= w_shift;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_cnt <= 4'd0;
                            if (w_shift[7:1] == ADDR) begin
                                r_state <= S_ADDR_ACK;
                                r_busy  <= 1'b1;
                                r_rw    <= w_sda;
                                r_phase <= 1'b0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_ADDR_ACK: if (w_scl_fall) begin
                        if (!r_phase) begin
                            r_oe    <= 1'b1;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            r_cnt   <= 4'd0;
                            if (!r_rw) begin
                                r_state <= S_WR_DATA;
                                r_oe    <= 1'b0;
                                r_first <= 1'b1;
                            end else begin
                                r_state    <= S_RD_DATA;
                                r_shift    <= w_rd_byte;
                                r_oe       <= ~w_rd_byte[7];
                                r_s_tready <= s_axis_tvalid;
                            end
                        end
                    end
                    S_WR_DATA: if (w_scl_rise) begin
                        r_shift <= w_shift;
                        r_cnt   <= r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            r_cnt   <= 4'd0;
                            r_state <= S_WR_ACK;
                            r_phase <= 1'b0;
                            r_ack   <= w_free;
                            if (w_free) begin
                                r_tdata  <= w_shift;
                                r_tvalid <= 1'b1;
                                r_tuser  <= r_first;
                                r_first  <= 1'b0;
                            end
                        end
                    end
                    S_WR_ACK: if (w_scl_fall) begin
                        if (!r_phase) begin
                            r_oe    <= r_ack;
                            r_phase <= 1'b1;
                        end else begin
                            r_oe    <= 1'b0;
                            r_phase <= 1'b0;
                            r_state <= S_WR_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        if (w_scl_rise) r_cnt <= r_cnt + 4'd1;
                        if (w_scl_fall) begin
                            if (r_cnt == 4'd8) begin
                                r_oe    <= 1'b0;
                                r_state <= S_RD_ACK;
                                r_phase <= 1'b0;
                            end else begin
                                r_oe <= ~r_shift[3'd7 - r_cnt[2:0]];
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            r_ack   <= ~w_sda;
                            r_phase <= 1'b1;
                        end else if (w_scl_fall && r_phase) begin
                            r_phase <= 1'b0;
                            r_cnt   <= 4'd0;
                            if (r_ack) begin
                                r_state    <= S_RD_DATA;
                                r_shift    <= w_rd_byte;
                                r_oe       <= ~w_rd_byte[7];
                                r_s_tready <= s_axis_tvalid;
                            end else begin
                                r_state <= S_IDLE;
                                r_oe    <= 1'b0;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign sda_oe_o      = r_oe;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tuser  = r_tuser;
    assign s_axis_tready = r_s_tready;
    assign busy_o        = r_busy;
endmodule

// File: tb/tb_i2c_axis_target.sv
// Directed bench: a bit-banged I2C controller on a wired-AND SDA line drives the target.
module tb_i2c_axis_target;
    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0, arstn = 1'b0, scl = 1'b1, m_sda = 1'b1, tready = 1'b1;
    logic       sda_line, sda_oe, m_tvalid, m_tuser, s_tvalid, s_tready, busy;
    logic [7:0] m_tdata, s_tdata;

    logic [8:0] mq[$];
    int         rd_pulses = 0, rd_base = 0, rd_len = 0, rd_i, oe_cnt = 0;
    logic [7:0] rd_tbl[0:3];
    int         n_pass = 0, n_total = 0;

    assign sda_line = m_sda & ~sda_oe;
    always #5 clk = ~clk;

    i2c_axis_target #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk_i(clk), .arstn_i(arstn), .scl_i(scl), .sda_i(sda_line), .sda_oe_o(sda_oe),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(tready),
        .m_axis_tuser(m_tuser), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .busy_o(busy)
    );

    // Read-data source: advances through rd_tbl on every consumption pulse
    always_comb begin
        rd_i     = rd_pulses - rd_base;
        s_tvalid = (rd_i < rd_len);
        s_tdata  = (rd_i >= 0 && rd_i < 4) ? rd_tbl[rd_i[1:0]] : 8'h00;
    end

    always @(negedge clk) begin
        if (m_tvalid && tready) mq.push_back({m_tuser, m_tdata});
        if (s_tready) rd_pulses++;
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [8:0] qget(input int i);
        return (mq.size() > i) ? mq[i] : 9'h1FF;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        scl   = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    tick(Q);
        scl   = 1'b1; tick(2 * Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; tick(Q);
        scl   = 1'b1; tick(Q);
        b     = sda_line; tick(Q);
        scl   = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(~ack);
    endtask

    task automatic load_rd(input int len, input logic [7:0] b0, input logic [7:0] b1);
        rd_tbl[0] = b0; rd_tbl[1] = b1; rd_tbl[2] = 8'hEE; rd_tbl[3] = 8'hEE;
        rd_base = rd_pulses;
        rd_len  = len;
    endtask

    initial begin
        logic       a0, a1, a2;
        logic [7:0] d0, d1;
        int         p0, o0, q0;

        load_rd(0, 8'h00, 8'h00);
        tick(5);
        check("rst_oe",     {15'd0, sda_oe},   16'd0);
        check("rst_tvalid", {15'd0, m_tvalid}, 16'd0);
        check("rst_tuser",  {15'd0, m_tuser},  16'd0);
        check("rst_busy",   {15'd0, busy},     16'd0);
        check("rst_tdata",  {8'd0, m_tdata},   16'd0);
        arstn = 1'b1;
        tick(5);

        // Write 0xA5, 0x3C
        i2c_start();
        write_byte(8'hA0, a0);
        check("wr_addr_ack", {15'd0, a0},   16'd1);
        check("wr_busy",     {15'd0, busy}, 16'd1);
        write_byte(8'hA5, a1);
        write_byte(8'h3C, a2);
        check("wr_ack_a5", {15'd0, a1}, 16'd1);
        check("wr_ack_3c", {15'd0, a2}, 16'd1);
        i2c_stop();
        tick(4);
        check("wr_busy_stop", {15'd0, busy},              16'd0);
        check("wr_count",     16'(mq.size()),             16'd2);
        check("wr_byte0",     {7'd0, qget(0)},            16'h1A5);
        check("wr_byte1",     {7'd0, qget(1)},            16'h03C);
        $display("txn write: addr_ack=%0b acks=%0b%0b bytes=%0d", a0, a1, a2, mq.size());

        // Read 0x81, 0x7E
        load_rd(2, 8'h81, 8'h7E);
        p0 = rd_pulses;
        i2c_start();
        write_byte(8'hA1, a0);
        check("rd_addr_ack", {15'd0, a0}, 16'd1);
        read_byte(d0, 1'b1);
        read_byte(d1, 1'b0);
        check("rd_byte0",    {8'd0, d0},     16'h81);
        check("rd_byte1",    {8'd0, d1},     16'h7E);
        check("rd_oe_nack",  {15'd0, sda_oe}, 16'd0);
        check("rd_busy_hold", {15'd0, busy},  16'd1);
        i2c_stop();
        tick(4);
        check("rd_busy_stop", {15'd0, busy},        16'd0);
        check("rd_pulses",    16'(rd_pulses - p0),  16'd2);
        $display("txn read: data=%02h %02h pulses=%0d", d0, d1, rd_pulses - p0);
        load_rd(0, 8'h00, 8'h00);

        // Address mismatch
        o0 = oe_cnt; q0 = mq.size();
        i2c_start();
        write_byte(8'hA2, a0);
        check("mm_addr_nack", {15'd0, a0},   16'd0);
        check("mm_busy",      {15'd0, busy}, 16'd0);
        write_byte(8'hFF, a1);
        i2c_stop();
        tick(4);
        check("mm_oe_cycles", 16'(oe_cnt - o0),     16'd0);
        check("mm_no_stream", 16'(mq.size() - q0),  16'd0);
        check("mm_busy_end",  {15'd0, busy},        16'd0);
        $display("txn mismatch: ack=%0b oe_cycles=%0d", a0, oe_cnt - o0);

        // Backpressure
        tready = 1'b0;
        q0 = mq.size();
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h11, a1);
        write_byte(8'h22, a2);
        i2c_stop();
        tick(4);
        check("bp_ack_11",  {15'd0, a1},       16'd1);
        check("bp_nack_22", {15'd0, a2},       16'd0);
        check("bp_tvalid",  {15'd0, m_tvalid}, 16'd1);
        check("bp_tdata",   {8'd0, m_tdata},   16'h11);
        check("bp_tuser",   {15'd0, m_tuser},  16'd1);
        tready = 1'b1;
        tick(4);
        check("bp_count",      16'(mq.size() - q0), 16'd1);
        check("bp_delivered",  {7'd0, qget(q0)},    16'h111);
        check("bp_tvalid_clr", {15'd0, m_tvalid},   16'd0);
        $display("txn backpressure: acks=%0b%0b delivered=%0d", a1, a2, mq.size() - q0);

        // Repeated START into an underrunning read
        q0 = mq.size(); p0 = rd_pulses;
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h01, a1);
        i2c_start();
        write_byte(8'hA1, a2);
        read_byte(d0, 1'b0);
        i2c_stop();
        tick(4);
        check("sr_ack_01",   {15'd0, a1},          16'd1);
        check("sr_rd_ack",   {15'd0, a2},          16'd1);
        check("sr_delivered", {7'd0, qget(q0)},    16'h101);
        check("sr_underrun", {8'd0, d0},           16'hFF);
        check("sr_pulses",   16'(rd_pulses - p0),  16'd0);
        $display("txn rep_start: wr=%0b rd_ack=%0b data=%02h", a1, a2, d0);

        // Reset during bit 4 of a read byte of zeros
        load_rd(1, 8'h00, 8'h00);
        i2c_start();
        write_byte(8'hA1, a0);
        for (int i = 0; i < 3; i++) read_bit(a1);
        check("rm_oe_driving", {15'd0, sda_oe}, 16'd1);
        arstn = 1'b0;
        tick(1);
        check("rm_oe_rst",     {15'd0, sda_oe},   16'd0);
        check("rm_busy_rst",   {15'd0, busy},     16'd0);
        check("rm_tdata_rst",  {8'd0, m_tdata},   16'd0);
        arstn = 1'b1;
        load_rd(0, 8'h00, 8'h00);
        tick(4);
        q0 = mq.size();
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h5A, a1);
        i2c_stop();
        tick(4);
        check("rm_addr_ack", {15'd0, a0},       16'd1);
        check("rm_wr_ack",   {15'd0, a1},       16'd1);
        check("rm_delivered", {7'd0, qget(q0)}, 16'h15A);
        $display("txn reset_mid: rearm_ack=%0b%0b", a0, a1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
